hazard5_instr_compress_packer: RTL and testbench

- Streaming RV32I-to-RVC compressor and halfword packer for the toolchain-side loader/ROM builder path; the inverse of the Hazard5 fetch-side decompressor.
- Accepts one 32-bit instruction per handshake and re-encodes it as a 16-bit RVC instruction where a supported mapping exists; otherwise it passes the instruction through unchanged.
- Packs the resulting 16/32-bit stream little-endian into 32-bit memory words. 32-bit instructions may straddle word boundaries.

---
 rtl/hazard5_instr_compress_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_hazard5_instr_compress_packer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard5_instr_compress_packer.sv
// RV32I -> RVC compressor with little-endian halfword packing into 32-bit words.
module hazard5_instr_compress_packer #(
  parameter int unsigned ENABLE_COMPRESS = 1,
  parameter int unsigned W_COUNT         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic               in_flush,
  output logic               in_illegal,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_last,
  output logic               hw_pending,
  output logic [W_COUNT-1:0] n_compressed
);

  localparam logic EN = (ENABLE_COMPRESS != 0);

  typedef enum logic {ST_EMPTY, ST_HALF} state_t;

  state_t               state_q, state_d;
  logic [15:0]          held_q, held_d;
  logic                 out_valid_q;
  logic [31:0]          out_data_q;
  logic                 out_last_q;
  logic                 illegal_q;
  logic [W_COUNT-1:0]   n_q;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;
  logic        rd_c, rs1_c, rs2_c;
  logic        imm_small, lw_ok, lwsp_ok, sw_ok, swsp_ok;
  logic [15:0] c16;
  logic        is16_raw, is16;

  logic        accept, emit, last_d;
  logic [31:0] word_d;

  assign opc   = in_instr[6:0];
  assign rd    = in_instr[11:7];
  assign f3    = in_instr[14:12];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign f7    = in_instr[31:25];
  assign imm_i = in_instr[31:20];
  assign imm_s = {in_instr[31:25], in_instr[11:7]};

  assign rd_c  = (rd[4:3] == 2'b01);
  assign rs1_c = (rs1[4:3] == 2'b01);
  assign rs2_c = (rs2[4:3] == 2'b01);

  // Signed 12-bit immediate fits in 6 bits when its upper bits are pure sign extension
  assign imm_small = (imm_i[11:5] == '0) || (imm_i[11:5] == '1);
  assign lw_ok     = (imm_i[11:7] == '0) && (imm_i[1:0] == '0);
  assign lwsp_ok   = (imm_i[11:8] == '0) && (imm_i[1:0] == '0);
  assign sw_ok     = (imm_s[11:7] == '0) && (imm_s[1:0] == '0);
  assign swsp_ok   = (imm_s[11:8] == '0) && (imm_s[1:0] == '0);

  // Map the supported RV32I subset onto its 16-bit encoding
  always_comb begin
    c16      = '0;
    is16_raw = 1'b0;
    unique case (opc)
      7'b0010011: begin
        if (f3 == 3'b000) begin
          if (rs1 != '0 && rd == rs1 && imm_i != '0 && imm_small) begin
            c16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            is16_raw = 1'b1;
          end else if (rs1 == '0 && rd != '0 && imm_small) begin
            c16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            is16_raw = 1'b1;
          end
        end else if (f3 == 3'b001) begin
          if (f7 == '0 && rd == rs1 && rd != '0 && rs2 != '0) begin
            c16 = {3'b000, 1'b0, rd, rs2, 2'b10};
            is16_raw = 1'b1;
          end
        end else if (f3 == 3'b111) begin
          if (rd == rs1 && rd_c && imm_small) begin
            c16 = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
            is16_raw = 1'b1;
          end
        end
      end
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == '0 && rd != '0 && rs2 != '0) begin
          if (rs1 == '0) begin
            c16 = {4'b1000, rd, rs2, 2'b10};
            is16_raw = 1'b1;
          end else if (rd == rs1) begin
            c16 = {4'b1001, rd, rs2, 2'b10};
            is16_raw = 1'b1;
          end
        end else if (rd == rs1 && rd_c && rs2_c) begin
          is16_raw = 1'b1;
          unique case ({f7, f3})
            {7'b0100000, 3'b000}: c16 = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
            {7'b0000000, 3'b100}: c16 = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
            {7'b0000000, 3'b110}: c16 = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
            {7'b0000000, 3'b111}: c16 = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
            default:              is16_raw = 1'b0;
          endcase
        end
      end
      7'b0000011: begin
        if (f3 == 3'b010) begin
          if (rd_c && rs1_c && lw_ok) begin
            c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
            is16_raw = 1'b1;
          end else if (rd != '0 && rs1 == 5'd2 && lwsp_ok) begin
            c16 = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
            is16_raw = 1'b1;
          end
        end
      end
      7'b0100011: begin
        if (f3 == 3'b010) begin
          if (rs2_c && rs1_c && sw_ok) begin
            c16 = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
            is16_raw = 1'b1;
          end else if (rs1 == 5'd2 && swsp_ok) begin
            c16 = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
            is16_raw = 1'b1;
          end
        end
      end
      7'b1100111: begin
        if (f3 == 3'b000 && imm_i == '0 && rs1 != '0) begin
          if (rd == 5'd0) begin
            c16 = {4'b1000, rs1, 5'd0, 2'b10};
            is16_raw = 1'b1;
          end else if (rd == 5'd1) begin
            c16 = {4'b1001, rs1, 5'd0, 2'b10};
            is16_raw = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign is16       = is16_raw && EN;
  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign in_illegal = illegal_q;
  assign hw_pending = (state_q == ST_HALF);
  assign n_compressed = n_q;

  // Packing next-state: decide held halfword and the word (if any) this accept produces
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    emit    = 1'b0;
    word_d  = '0;
    last_d  = 1'b0;
    if (accept) begin
      if (in_flush) begin
        if (state_q == ST_HALF) begin
          emit    = 1'b1;
          word_d  = {16'h0001, held_q};
          last_d  = 1'b1;
          state_d = ST_EMPTY;
        end
      end else if (is16) begin
        if (state_q == ST_EMPTY) begin
          held_d  = c16;
          state_d = ST_HALF;
        end else begin
          emit    = 1'b1;
          word_d  = {c16, held_q};
          state_d = ST_EMPTY;
        end
      end else begin
        emit = 1'b1;
        if (state_q == ST_EMPTY) begin
          word_d = in_instr;
        end else begin
          // Straddling: low half completes this word, high half becomes the new held halfword
          word_d = {in_instr[15:0], held_q};
          held_d = in_instr[31:16];
        end
      end
    end
  end

  // State, output register, illegal pulse and statistics counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      held_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      illegal_q   <= 1'b0;
      n_q         <= '0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      illegal_q <= accept && !in_flush && (in_instr[1:0] != 2'b11);
      if (in_ready) begin
        out_valid_q <= emit;
        if (emit) begin
          out_data_q <= word_d;
          out_last_q <= last_d;
        end
      end
      if (accept && !in_flush && is16) begin
        n_q <= n_q + W_COUNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard5_instr_compress_packer.sv
// Randomized bench for the compressor/packer against a halfword-queue reference model.
module tb_hazard5_instr_compress_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        in_flush;
  logic        in_illegal;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        hw_pending;
  logic [15:0] n_compressed;

  logic        in_ready0, in_illegal0, out_valid0, out_last0, hw_pending0;
  logic [31:0] out_data0;
  logic [15:0] n_compressed0;

  hazard5_instr_compress_packer #(.ENABLE_COMPRESS(1), .W_COUNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_flush(in_flush), .in_illegal(in_illegal),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .hw_pending(hw_pending), .n_compressed(n_compressed)
  );

  hazard5_instr_compress_packer #(.ENABLE_COMPRESS(0), .W_COUNT(16)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_flush(in_flush), .in_illegal(in_illegal0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0), .hw_pending(hw_pending0), .n_compressed(n_compressed0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [15:0] hq[$];
  bit          m_ov;
  logic [31:0] m_word;
  bit          m_last;
  bit          m_ill;
  logic [15:0] m_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_rp(input int r);
    return r >= 8 && r <= 15;
  endfunction

  // Reference compressor: returns {is16, c16} using integer field values and ranges
  function automatic logic [16:0] ref_comp(input logic [31:0] i);
    int op, f3, f7, rd, rs1, rs2, imm, simm;
    logic [4:0]  rdb, rs1b, rs2b;
    logic [31:0] ib, sb;
    op = int'(i[6:0]); f3 = int'(i[14:12]); f7 = int'(i[31:25]);
    rdb = i[11:7]; rs1b = i[19:15]; rs2b = i[24:20];
    rd = int'(rdb); rs1 = int'(rs1b); rs2 = int'(rs2b);
    imm  = int'($signed(i[31:20]));
    simm = int'($signed({i[31:25], i[11:7]}));
    ib = imm; sb = simm;
    if (op == 19 && f3 == 0 && rs1 != 0 && rd == rs1 && imm != 0 && imm >= -32 && imm <= 31)
      return {1'b1, 3'b000, ib[5], rdb, ib[4:0], 2'b01};
    if (op == 19 && f3 == 0 && rs1 == 0 && rd != 0 && imm >= -32 && imm <= 31)
      return {1'b1, 3'b010, ib[5], rdb, ib[4:0], 2'b01};
    if (op == 19 && f3 == 1 && f7 == 0 && rd == rs1 && rd != 0 && rs2 != 0)
      return {1'b1, 3'b000, 1'b0, rdb, rs2b, 2'b10};
    if (op == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs1 == 0 && rs2 != 0)
      return {1'b1, 4'b1000, rdb, rs2b, 2'b10};
    if (op == 51 && f3 == 0 && f7 == 0 && rd == rs1 && rd != 0 && rs2 != 0)
      return {1'b1, 4'b1001, rdb, rs2b, 2'b10};
    if (op == 51 && rd == rs1 && is_rp(rd) && is_rp(rs2)) begin
      if (f7 == 32 && f3 == 0) return {1'b1, 6'b100011, rdb[2:0], 2'd0, rs2b[2:0], 2'b01};
      if (f7 == 0  && f3 == 4) return {1'b1, 6'b100011, rdb[2:0], 2'd1, rs2b[2:0], 2'b01};
      if (f7 == 0  && f3 == 6) return {1'b1, 6'b100011, rdb[2:0], 2'd2, rs2b[2:0], 2'b01};
      if (f7 == 0  && f3 == 7) return {1'b1, 6'b100011, rdb[2:0], 2'd3, rs2b[2:0], 2'b01};
    end
    if (op == 19 && f3 == 7 && rd == rs1 && is_rp(rd) && imm >= -32 && imm <= 31)
      return {1'b1, 3'b100, ib[5], 2'b10, rdb[2:0], ib[4:0], 2'b01};
    if (op == 3 && f3 == 2 && is_rp(rd) && is_rp(rs1) && imm >= 0 && imm <= 124 && imm % 4 == 0)
      return {1'b1, 3'b010, ib[5:3], rs1b[2:0], ib[2], ib[6], rdb[2:0], 2'b00};
    if (op == 3 && f3 == 2 && rd != 0 && rs1 == 2 && imm >= 0 && imm <= 252 && imm % 4 == 0)
      return {1'b1, 3'b010, ib[5], rdb, ib[4:2], ib[7:6], 2'b10};
    if (op == 35 && f3 == 2 && is_rp(rs2) && is_rp(rs1) && simm >= 0 && simm <= 124 && simm % 4 == 0)
      return {1'b1, 3'b110, sb[5:3], rs1b[2:0], sb[2], sb[6], rs2b[2:0], 2'b00};
    if (op == 35 && f3 == 2 && rs1 == 2 && simm >= 0 && simm <= 252 && simm % 4 == 0)
      return {1'b1, 3'b110, sb[5:2], sb[7:6], rs2b, 2'b10};
    if (op == 103 && f3 == 0 && imm == 0 && rs1 != 0 && rd == 0)
      return {1'b1, 4'b1000, rs1b, 5'd0, 2'b10};
    if (op == 103 && f3 == 0 && imm == 0 && rs1 != 0 && rd == 1)
      return {1'b1, 4'b1001, rs1b, 5'd0, 2'b10};
    return '0;
  endfunction

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return 8 + int'($urandom_range(0, 7));
    if (r == 5) return 0;
    if (r == 6) return 2;
    if (r == 7) return 1;
    return int'($urandom_range(0, 31));
  endfunction

  function automatic int pick_imm();
    if ($urandom_range(0, 9) < 6) return int'($urandom_range(0, 80)) - 40;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic int pick_off();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 4 * int'($urandom_range(0, 66));
    if (r < 8) return int'($urandom_range(0, 260));
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] a, b, c, d, e;
    a = imm; b = rs1; c = f3; d = rd; e = op;
    return {a[11:0], b[4:0], c[2:0], d[4:0], e[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] a, b;
    a = f7; b = rs2;
    return {a[6:0], b[4:0], 20'h0} | (enc_i(0, rs1, f3, rd, op) & 32'h000f_ffff);
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3, input int op);
    logic [31:0] a, b, c, d, e;
    a = imm; b = rs2; c = rs1; d = f3; e = op;
    return {a[11:5], b[4:0], c[4:0], d[2:0], a[4:0], e[6:0]};
  endfunction

  function automatic logic [31:0] gen_instr();
    int k, rd, rs1, f3;
    logic [31:0] r;
    k = int'($urandom_range(0, 10));
    rd = pick_reg();
    rs1 = ($urandom_range(0, 1) == 1) ? rd : pick_reg();
    r = $urandom;
    case (k)
      0: return enc_i(pick_imm(), rs1, 0, rd, 19);
      1: return enc_r(($urandom_range(0, 7) == 0) ? 32 : 0, int'($urandom_range(0, 31)), rs1, 1, rd, 19);
      2: return enc_r(0, pick_reg(), ($urandom_range(0, 2) == 0) ? 0 : rs1, 0, rd, 51);
      3: begin
        f3 = ($urandom_range(0, 3) == 0) ? 0 : 4 + 2 * int'($urandom_range(0, 1)) + int'($urandom_range(0, 1));
        return enc_r(($urandom_range(0, 1) == 1) ? 32 : 0, pick_reg(), rs1, f3, rd, 51);
      end
      4: return enc_i(pick_imm(), rs1, 7, rd, 19);
      5: return enc_i(pick_off(), pick_reg(), 2, rd, 3);
      6: return enc_s(pick_off(), pick_reg(), pick_reg(), 2, 35);
      7: return enc_i(($urandom_range(0, 2) == 0) ? pick_imm() : 0, pick_reg(), 0, int'($urandom_range(0, 2)), 103);
      8: return r | 32'h3;
      9: return r;
      default: return {r[31:7], 7'h37};
    endcase
  endfunction

  task automatic compare_outputs();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_data", out_data, m_word);
      check("out_last", 32'(out_last), 32'(m_last));
    end
    check("hw_pending", 32'(hw_pending), 32'(hq.size() == 1));
    check("in_illegal", 32'(in_illegal), 32'(m_ill));
    check("n_compressed", 32'(n_compressed), 32'(m_n));
  endtask

  // One clock cycle: drive, check in_ready, advance the model, compare after the edge
  task automatic step(input bit v, input logic [31:0] instr, input bit fl, input bit ordy);
    bit acc, rdy, prod;
    logic [16:0] rc;
    logic [31:0] w;
    @(negedge clk);
    in_valid = v; in_instr = instr; in_flush = fl; out_ready = ordy;
    #1;
    rdy = !m_ov || ordy;
    check("in_ready", 32'(in_ready), 32'(rdy));
    acc = v && rdy;
    prod = 1'b0;
    w = '0;
    if (acc) begin
      if (fl) begin
        if (hq.size() == 1) hq.push_back(16'h0001);
      end else begin
        rc = ref_comp(instr);
        if (rc[16]) begin
          hq.push_back(rc[15:0]);
          m_n = m_n + 16'd1;
        end else begin
          hq.push_back(instr[15:0]);
          hq.push_back(instr[31:16]);
        end
      end
      if (hq.size() >= 2) begin
        w = {hq[1], hq[0]};
        void'(hq.pop_front());
        void'(hq.pop_front());
        prod = 1'b1;
      end
    end
    if (rdy) begin
      m_ov = prod;
      if (prod) begin
        m_word = w;
        m_last = fl;
      end
    end
    m_ill = acc && !fl && (instr[1:0] != 2'b11);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_flush = 1'b0;
    hq.delete();
    m_ov = 1'b0; m_word = '0; m_last = 1'b0; m_ill = 1'b0; m_n = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_illegal", 32'(in_illegal), 32'd0);
    check("rst_hw_pending", 32'(hw_pending), 32'd0);
    check("rst_n_compressed", 32'(n_compressed), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_flush = 1'b0; out_ready = 1'b1;
    hq.delete();
    m_ov = 1'b0; m_word = '0; m_last = 1'b0; m_ill = 1'b0; m_n = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // C.ADDI + C.MV pair into one word
    step(1, 32'h00140413, 0, 1);
    step(1, 32'h00B00533, 0, 1);
    check("tp1_word", out_data, 32'h852E0405);
    check("tp1_last", 32'(out_last), 32'd0);
    check("tp1_ncomp", 32'(n_compressed), 32'd2);
    check("tp1_pending", 32'(hw_pending), 32'd0);
    step(0, '0, 0, 1);

    // C.LW then flush pads with C.NOP
    step(1, 32'h00452483, 0, 1);
    step(1, '0, 1, 1);
    check("tp2_word", out_data, 32'h00014144);
    check("tp2_last", 32'(out_last), 32'd1);

    // Straddling 32-bit instruction then flush
    step(1, 32'h00140413, 0, 1);
    step(1, 32'h06408093, 0, 1);
    check("tp3_word0", out_data, 32'h80930405);
    step(1, '0, 1, 1);
    check("tp3_word1", out_data, 32'h00010640);
    check("tp3_last", 32'(out_last), 32'd1);

    // Compression disabled instance
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00140413, 0, 1);
      check("nc_valid", 32'(out_valid0), 32'd1);
      check("nc_word", out_data0, 32'h00140413);
      check("nc_pending", 32'(hw_pending0), 32'd0);
      check("nc_ncomp", 32'(n_compressed0), 32'd0);
    end
    step(1, '0, 1, 1);

    // Backpressure: output held stable, then release with same-cycle accept
    step(0, '0, 0, 1);
    step(1, 32'h12345037, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h06408093, 0, 0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_data", out_data, 32'h12345037);
    end
    step(1, 32'h06408093, 0, 1);
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_data", out_data, 32'h06408093);

    // Non-32-bit-form input passes through with illegal pulse
    step(1, 32'h00000001, 0, 1);
    check("ill_word", out_data, 32'h00000001);
    check("ill_pulse", 32'(in_illegal), 32'd1);
    step(0, '0, 0, 1);
    check("ill_clear", 32'(in_illegal), 32'd0);

    // Flush with nothing pending produces nothing
    step(1, '0, 1, 1);
    check("empty_flush", 32'(out_valid), 32'd0);

    // Async reset with a held halfword
    step(1, 32'h00140413, 0, 1);
    check("pre_rst_pending", 32'(hw_pending), 32'd1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, gen_instr(), $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    step(1, '0, 1, 1);
    step(0, '0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
